// File: rtl/scr1_ialu_rvm_seq.sv
// scr1_ialu_rvm_seq: multi-cycle RV32M/RV64M multiply/divide unit with abort and divide fast paths
module scr1_ialu_rvm_seq #(
  parameter int SCR1_XLEN           = 32,
  parameter int SCR1_IALU_CMD_WIDTH = 5,
  parameter int MUL_BITS_PER_CYCLE  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ialu_rvm_cmd_vd_i,
  input  logic [SCR1_IALU_CMD_WIDTH-1:0] ialu_cmd_i,
  input  logic [SCR1_XLEN-1:0]           ialu_main_op1_i,
  input  logic [SCR1_XLEN-1:0]           ialu_main_op2_i,
  output logic [SCR1_XLEN-1:0]           ialu_main_res_o,
  output logic                           ialu_rvm_res_rdy_o,
  output logic                           ialu_rvm_busy_o
);
  localparam int X  = SCR1_XLEN;
  localparam int B  = MUL_BITS_PER_CYCLE;
  localparam int CW = $clog2(X);
  localparam logic [CW-1:0] MUL_LAST = CW'(X / B - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(X - 1);
  localparam logic [X-1:0]  MIN_VAL  = {1'b1, {(X-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          state_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [X-1:0]    b_q, res_q;
  logic [2*X-1:0]  acc_q;
  logic [CW-1:0]   cnt_q;
  logic            cmd_ok, sgn1, sgn2, neg1, neg2, rem_i, div0, ovf;
  logic [2:0]      op_i;
  logic [X-1:0]    abs1, abs2, fast_res, dres, fin;
  logic [X+B-1:0]  hi_sum;
  logic [X:0]      rem_sh, diff;
  logic [2*X-1:0]  mul_n, div_n, acc_n, prod;
  assign op_i     = ialu_cmd_i[2:0];
  assign cmd_ok   = ialu_cmd_i >= SCR1_IALU_CMD_WIDTH'(16) && ialu_cmd_i <= SCR1_IALU_CMD_WIDTH'(23);
  assign sgn1     = op_i inside {3'd1, 3'd2, 3'd4, 3'd6};
  assign sgn2     = op_i inside {3'd1, 3'd4, 3'd6};
  assign neg1     = sgn1 & ialu_main_op1_i[X-1];
  assign neg2     = sgn2 & ialu_main_op2_i[X-1];
  assign abs1     = neg1 ? -ialu_main_op1_i : ialu_main_op1_i;
  assign abs2     = neg2 ? -ialu_main_op2_i : ialu_main_op2_i;
  assign rem_i    = op_i[2] & op_i[1];
  assign div0     = op_i[2] && ialu_main_op2_i == '0;
  assign ovf      = op_i[2] && !op_i[0] && ialu_main_op1_i == MIN_VAL && ialu_main_op2_i == '1;
  assign fast_res = rem_i ? (div0 ? ialu_main_op1_i : '0) : (div0 ? '1 : MIN_VAL);
  // Multiply: add b * (low B multiplier bits) into the high half, then shift the whole accumulator right
  assign hi_sum   = {{B{1'b0}}, acc_q[2*X-1:X]} + {{B{1'b0}}, b_q} * {{X{1'b0}}, acc_q[B-1:0]};
  assign mul_n    = {hi_sum, acc_q[X-1:B]};
  // Divide: high half is the partial remainder, low half shifts dividend out and quotient in
  assign rem_sh   = {acc_q[2*X-1:X], acc_q[X-1]};
  assign diff     = rem_sh - {1'b0, b_q};
  assign div_n    = diff[X] ? {rem_sh[X-1:0], acc_q[X-2:0], 1'b0} : {diff[X-1:0], acc_q[X-2:0], 1'b1};
  assign acc_n    = op_q[2] ? div_n : mul_n;
  assign prod     = neg_q ? -acc_n : acc_n;
  assign dres     = op_q[1] ? acc_n[2*X-1:X] : acc_n[X-1:0];
  assign fin      = op_q[2] ? (neg_q ? -dres : dres) : (op_q[1:0] == 2'd0 ? prod[X-1:0] : prod[2*X-1:X]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (ialu_rvm_cmd_vd_i && cmd_ok) begin
          op_q    <= op_i;
          neg_q   <= neg1 ^ (neg2 & ~rem_i);
          b_q     <= abs2;
          acc_q   <= {{X{1'b0}}, abs1};
          cnt_q   <= op_i[2] ? DIV_LAST : MUL_LAST;
          res_q   <= (div0 || ovf) ? fast_res : res_q;
          state_q <= (div0 || ovf) ? DONE : CALC;
        end
        CALC: if (!ialu_rvm_cmd_vd_i) begin
          state_q <= IDLE;
        end else begin
          acc_q   <= acc_n;
          cnt_q   <= cnt_q - CW'(1);
          res_q   <= cnt_q == '0 ? fin : res_q;
          state_q <= cnt_q == '0 ? DONE : CALC;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ialu_main_res_o    = res_q;
  assign ialu_rvm_res_rdy_o = state_q == DONE;
  assign ialu_rvm_busy_o    = state_q != IDLE;
endmodule

// File: tb/tb_scr1_ialu_rvm_seq.sv
// tb_scr1_ialu_rvm_seq: three configurations (32/1, 32/4, 64/8) checked against a wide-arithmetic model
module tb_scr1_ialu_rvm_seq;
  logic        clk = 1'b0, rst_n = 1'b0, vd = 1'b0;
  logic [4:0]  cmd = '0;
  logic [63:0] op1 = '0, op2 = '0;
  logic [31:0] res0, res1;
  logic [63:0] res2, res_s;
  logic        rdy0, rdy1, rdy2, busy0, busy1, busy2, rdy_s, busy_s;
  logic        vd0, vd1, vd2;
  int          sel = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign vd0 = vd && sel == 0;
  assign vd1 = vd && sel == 1;
  assign vd2 = vd && sel == 2;
  always_comb begin
    res_s  = sel == 2 ? res2 : {32'd0, sel == 1 ? res1 : res0};
    rdy_s  = sel == 2 ? rdy2 : sel == 1 ? rdy1 : rdy0;
    busy_s = sel == 2 ? busy2 : sel == 1 ? busy1 : busy0;
  end
  scr1_ialu_rvm_seq #(.SCR1_XLEN(32), .SCR1_IALU_CMD_WIDTH(5), .MUL_BITS_PER_CYCLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .ialu_rvm_cmd_vd_i(vd0), .ialu_cmd_i(cmd),
    .ialu_main_op1_i(op1[31:0]), .ialu_main_op2_i(op2[31:0]),
    .ialu_main_res_o(res0), .ialu_rvm_res_rdy_o(rdy0), .ialu_rvm_busy_o(busy0));
  scr1_ialu_rvm_seq #(.SCR1_XLEN(32), .SCR1_IALU_CMD_WIDTH(5), .MUL_BITS_PER_CYCLE(4)) u1 (
    .clk(clk), .rst_n(rst_n), .ialu_rvm_cmd_vd_i(vd1), .ialu_cmd_i(cmd),
    .ialu_main_op1_i(op1[31:0]), .ialu_main_op2_i(op2[31:0]),
    .ialu_main_res_o(res1), .ialu_rvm_res_rdy_o(rdy1), .ialu_rvm_busy_o(busy1));
  scr1_ialu_rvm_seq #(.SCR1_XLEN(64), .SCR1_IALU_CMD_WIDTH(5), .MUL_BITS_PER_CYCLE(8)) u2 (
    .clk(clk), .rst_n(rst_n), .ialu_rvm_cmd_vd_i(vd2), .ialu_cmd_i(cmd),
    .ialu_main_op1_i(op1), .ialu_main_op2_i(op2),
    .ialu_main_res_o(res2), .ialu_rvm_res_rdy_o(rdy2), .ialu_rvm_busy_o(busy2));
  function automatic int xlen(input int w);
    return w == 2 ? 64 : 32;
  endfunction
  function automatic logic [63:0] msk(input int w);
    return w == 2 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction
  // Exact wide signed/unsigned arithmetic; truncating division and dividend-signed remainder come from SV itself
  function automatic logic [63:0] model(input int w, input logic [2:0] op, input logic [63:0] a_in, b_in);
    logic [63:0] a, b;
    logic signed [129:0] ua, ub, sa, sb, r;
    int x;
    x = xlen(w);
    a = a_in & msk(w);
    b = b_in & msk(w);
    ua = {66'd0, a};
    ub = {66'd0, b};
    sa = a[x-1] ? ua - (130'sd1 <<< x) : ua;
    sb = b[x-1] ? ub - (130'sd1 <<< x) : ub;
    case (op)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> x;
      3'd2: r = (sa * ub) >>> x;
      3'd3: r = (ua * ub) >>> x;
      3'd4: r = b == 0 ? -130'sd1 : sa / sb;
      3'd5: r = b == 0 ? -130'sd1 : ua / ub;
      3'd6: r = b == 0 ? ua : sa % sb;
      default: r = b == 0 ? ua : ua % ub;
    endcase
    return r[63:0] & msk(w);
  endfunction
  function automatic int lat_exp(input int w, input logic [2:0] op, input logic [63:0] a_in, b_in);
    logic [63:0] a, b, mn;
    int x, bpc;
    x = xlen(w);
    bpc = w == 0 ? 1 : w == 1 ? 4 : 8;
    a = a_in & msk(w);
    b = b_in & msk(w);
    mn = 64'd1 << (x - 1);
    if (op[2] && (b == 0 || (!op[0] && a == mn && b == msk(w)))) return 1;
    return op[2] ? x + 1 : x / bpc + 1;
  endfunction
  function automatic logic [63:0] pick(input int w);
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'd1 << (xlen(w) - 1);
      3: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction
  // Drives one command, scrambles the inputs during CALC, and reports what the DUT did
  task automatic issue(input int w, input logic [2:0] op, input logic [63:0] a, b,
                       output logic [63:0] r, output int lat, output int busy_lo,
                       output logic rdy_after, output logic busy_after);
    sel = w; vd = 1'b1; cmd = 5'(16 + int'(op)); op1 = a; op2 = b; lat = 0; busy_lo = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (rdy_s) begin lat = k; break; end
      if (!busy_s) busy_lo++;
      op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom}; cmd = 5'(16 + $urandom_range(0, 7));
    end
    r = res_s; vd = 1'b0;
    @(posedge clk); #1;
    rdy_after = rdy_s; busy_after = busy_s;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; #1;
    checks++;
    if ({res0, res1, res2} !== '0 || {rdy0, rdy1, rdy2, busy0, busy1, busy2} !== '0) begin
      errors++; $display("FAIL reset: res %h %h %h rdy/busy %b required all 0", res0, res1, res2,
                         {rdy0, rdy1, rdy2, busy0, busy1, busy2});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  typedef struct { int w; logic [2:0] op; logic [63:0] a, b, e; int l; } vec_t;
  task automatic test_directed;
    vec_t v[16] = '{
      '{0, 3'd0, 64'h7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 33},
      '{0, 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33},
      '{0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 33},
      '{0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 33},
      '{0, 3'd4, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 33},
      '{0, 3'd6, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF, 33},
      '{0, 3'd5, 64'd100, 64'd7, 64'd14, 33},
      '{0, 3'd7, 64'd100, 64'd7, 64'd2, 33},
      '{0, 3'd5, 64'd5, 64'd0, 64'hFFFF_FFFF, 1},
      '{0, 3'd6, 64'd5, 64'd0, 64'd5, 1},
      '{0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1},
      '{0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1},
      '{1, 3'd0, 64'h1234_5678, 64'h10, 64'h2345_6780, 9},
      '{1, 3'd5, 64'd100, 64'd7, 64'd14, 33},
      '{2, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE, 9},
      '{2, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1}};
    logic [63:0] r;
    int lat, blo;
    logic ra, ba;
    foreach (v[i]) begin
      issue(v[i].w, v[i].op, v[i].a, v[i].b, r, lat, blo, ra, ba);
      checks++;
      if (r !== v[i].e) begin errors++; $display("FAIL directed[%0d] result: got %h required %h", i, r, v[i].e); end
      checks++;
      if (lat != v[i].l) begin errors++; $display("FAIL directed[%0d] latency: got %0d required %0d", i, lat, v[i].l); end
      checks++;
      if (ra !== 1'b0 || ba !== 1'b0 || blo != 0) begin
        errors++; $display("FAIL directed[%0d] pulse/busy: rdy_after %b busy_after %b busy_low_cycles %0d required 0 0 0", i, ra, ba, blo);
      end
    end
  endtask
  task automatic test_random;
    logic [63:0] r, a, b, e;
    logic [2:0] op;
    int lat, blo, w;
    logic ra, ba;
    for (int i = 0; i < 150; i++) begin
      w = $urandom_range(0, 2); op = 3'($urandom_range(0, 7)); a = pick(w); b = pick(w);
      e = model(w, op, a, b);
      issue(w, op, a, b, r, lat, blo, ra, ba);
      checks++;
      if (r !== e || lat != lat_exp(w, op, a, b) || ra !== 1'b0 || ba !== 1'b0 || blo != 0) begin
        errors++; $display("FAIL random[%0d] cfg %0d op %0d a %h b %h: got res %h lat %0d required res %h lat %0d (rdy_after %b busy_after %b busy_low %0d)",
                           i, w, op, a, b, r, lat, e, lat_exp(w, op, a, b), ra, ba, blo);
      end
    end
  endtask
  task automatic test_abort;
    logic [63:0] r;
    int lat, blo, early;
    logic ra, ba;
    issue(0, 3'd5, 64'd100, 64'd7, r, lat, blo, ra, ba);
    sel = 0; vd = 1'b1; cmd = 5'd20; op1 = 64'd1000; op2 = 64'd3; early = 0;
    for (int k = 1; k <= 10; k++) begin @(posedge clk); #1; if (rdy_s) early++; end
    checks++;
    if (busy_s !== 1'b1 || early != 0) begin errors++; $display("FAIL abort pre: busy %b early_rdy %0d required 1 0", busy_s, early); end
    vd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (busy_s !== 1'b0 || rdy_s !== 1'b0 || res_s !== 64'd14) begin
        errors++; $display("FAIL abort post%0d: busy %b rdy %b res %h required 0 0 %h", k, busy_s, rdy_s, res_s, 64'd14);
      end
    end
    issue(0, 3'd3, 64'd3, 64'd5, r, lat, blo, ra, ba);
    checks++;
    if (r !== 64'd0 || lat != 33) begin errors++; $display("FAIL abort recovery MULHU: res %h lat %0d required 0 33", r, lat); end
  endtask
  task automatic test_back_to_back;
    int lat1, lat2;
    logic [63:0] r1;
    sel = 2; vd = 1'b1; cmd = 5'd16; op1 = 64'hFFFF_FFFF_FFFF_FFFF; op2 = 64'd3; lat1 = 0; lat2 = 0;
    for (int k = 1; k <= 40; k++) begin @(posedge clk); #1; if (rdy_s) begin lat1 = k; break; end end
    r1 = res_s; op1 = 64'd5; op2 = 64'd7;
    for (int k = 1; k <= 40; k++) begin @(posedge clk); #1; if (rdy_s) begin lat2 = k; break; end end
    checks++;
    if (r1 !== 64'hFFFF_FFFF_FFFF_FFFD || lat1 != 9) begin
      errors++; $display("FAIL b2b first: res %h lat %0d required FFFFFFFFFFFFFFFD 9", r1, lat1);
    end
    checks++;
    if (res_s !== 64'd35 || lat2 != 10) begin errors++; $display("FAIL b2b second: res %h lat %0d required 35 10", res_s, lat2); end
    vd = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_invalid;
    int bad;
    sel = 0; bad = 0; vd = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cmd = 5'(k < 3 ? $urandom_range(0, 15) : $urandom_range(24, 31));
      @(posedge clk); #1;
      if (busy_s !== 1'b0 || rdy_s !== 1'b0) bad++;
    end
    vd = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL invalid cmd: %0d cycles busy/rdy, required 0", bad); end
  endtask
  task automatic test_reset_mid;
    logic [63:0] r;
    int lat, blo;
    logic ra, ba;
    issue(0, 3'd0, 64'd7, 64'd3, r, lat, blo, ra, ba);
    sel = 0; vd = 1'b1; cmd = 5'd20; op1 = 64'd1000; op2 = 64'd3;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy_s !== 1'b1 || res_s !== 64'd21) begin errors++; $display("FAIL reset_mid pre: busy %b res %h required 1 21", busy_s, res_s); end
    rst_n = 1'b0; #1;
    checks++;
    if (res0 !== '0 || rdy0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL reset_mid: res %h rdy %b busy %b required 0 0 0", res0, rdy0, busy0);
    end
    vd = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 3'd7, 64'd100, 64'd7, r, lat, blo, ra, ba);
    checks++;
    if (r !== 64'd2 || lat != 33) begin errors++; $display("FAIL reset_mid recovery REMU: res %h lat %0d required 2 33", r, lat); end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_abort;
    test_back_to_back;
    test_invalid;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scr1_ialu_rvm_seq.md
Name: scr1_ialu_rvm_seq

Overview:
Parametrised multi-cycle RV32M/RV64M multiply/divide unit for the SCR1 integer ALU. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU under the existing ialu_rvm_cmd_vd / ialu_rvm_res_rdy handshake. Compared with the current fixed unit, it adds configurable XLEN, configurable multiplier radix (bits per cycle), fast-path division corner cases, and abort on command withdrawal. It sits beside the main ALU datapath, sharing the main operand buses.

Parameters:
SCR1_XLEN, 32, operand/result width; legal values 32 or 64.
SCR1_IALU_CMD_WIDTH, 5, width of ialu_cmd_i.
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values 1, 2, 4, 8; must divide SCR1_XLEN.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ialu_rvm_cmd_vd_i  input  1  RVM command valid; held with stable cmd/operands until res_rdy
ialu_cmd_i  input  SCR1_IALU_CMD_WIDTH  command code
ialu_main_op1_i  input  SCR1_XLEN  rs1 operand
ialu_main_op2_i  input  SCR1_XLEN  rs2 operand
ialu_main_res_o  output  SCR1_XLEN  result register
ialu_rvm_res_rdy_o  output  1  one-cycle pulse, result valid
ialu_rvm_busy_o  output  1  high whenever state != IDLE

Behaviour:
- Command codes: MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
- Any other code with cmd_vd=1 is ignored: state stays IDLE and no res_rdy is produced.
- Reset (async, any state): state=IDLE, ialu_main_res_o=0, ialu_rvm_res_rdy_o=0, busy=0, counter=0. Reset mid-operation discards the operation.
- FSM states: IDLE, CALC, DONE.
- IDLE, with cmd_vd=1 and a valid code, at the edge (cycle 0):
  - Latch the command.
  - For signed operands, latch absolute values plus result-sign flags: MULH uses op1 and op2 signed; MULHSU uses op1 signed only; DIV/REM use signed operands.
  - Load counter with N-1 and go to CALC.
  - N = SCR1_XLEN/MUL_BITS_PER_CYCLE for multiplies; N = SCR1_XLEN for divides.
- Fast path: divide with op2==0, or signed DIV/REM with op1=MIN and op2=-1.
  - Go directly IDLE->DONE; res_rdy is asserted in cycle 1.
  - Divide-by-zero: quotient = all-ones; remainder = op1 (unmodified).
  - Overflow: quotient = MIN; remainder = 0.
- CALC, one iteration per cycle:
  - Multiply: shift-add over a 2*XLEN accumulator, MUL_BITS_PER_CYCLE multiplier bits per cycle.
  - Divide: restoring radix-2, one quotient bit per cycle.
  - When counter==0, the final iteration completes at the edge: apply sign correction (two's-complement negate when the sign flag is set), load ialu_main_res_o, go to DONE.
  - Result selection: MUL takes the low XLEN bits; MULH* take the high XLEN bits. Quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
- Latency (cycle 0 = first cmd_vd cycle seen in IDLE): res_rdy_o high in cycle N+1.
  - XLEN=32: DIV/MUL(BPC=1) at cycle 33; MUL(BPC=4) at cycle 9.
- DONE: ialu_rvm_res_rdy_o=1 for exactly this cycle. cmd_vd is ignored. Next state is IDLE unconditionally. A back-to-back command can be accepted in the following IDLE cycle.
- ialu_main_res_o holds its value until the next DONE load. It is not cleared by an abort.
- Abort: cmd_vd_i=0 in any CALC cycle -> IDLE at the next edge; no res_rdy; result register unchanged.
- Operand or command changes while in CALC are ignored; latched values are used.
- Arithmetic is modulo 2^XLEN. No exceptions are raised.

Test Plan:
- XLEN=32, BPC=1: MUL 7 * 0xFFFFFFFD -> res=0xFFFFFFEB, res_rdy a single pulse at cycle 33, busy high in cycles 1..33.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE; each at cycle 33.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; each at cycle 33.
- Fast paths: DIVU 5/0 -> 0xFFFFFFFF at cycle 1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; all at cycle 1.
- Abort and reset: drop cmd_vd at cycle 10 of a DIV -> no res_rdy, busy=0 at cycle 11, res unchanged; then MULHU 3*5 -> 0 at cycle 33. Assert rst_n=0 mid-CALC -> all outputs 0 immediately.
- BPC=4, then XLEN=64 with BPC=8: MUL 0x12345678*0x10 -> 0x23456780 at cycle 9; XLEN=64 MUL 0xFFFFFFFFFFFFFFFF*2 -> 0xFFFFFFFFFFFFFFFE at cycle 9; back-to-back command accepted the cycle after DONE.
